// File: rtl/write_channel_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : write_channel_axi_pkg
// Description : Shared types and constants for the AXI4 line-write channel:
//               the channel state encoding, AXI burst/response codes, and the
//               AW length/size field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package write_channel_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int AWLEN_W  = 8;
    localparam int AWSIZE_W = 3;

    // Counter width able to hold values 0..value-1, never narrower than 1 bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_beat_serializer.sv
`default_nettype none
// ============================================================================
// Module      : write_beat_serializer
// Description : Holds one captured cache line and presents it one AXI beat at
//               a time, word 0 first, together with the matching strobe slice
//               and the last-beat flag.
// Ports       : ap_clk, reset     - clock, synchronous active-high reset
//               load              - capture line_data/line_strb, rewind to beat 0
//               line_data/strb    - full line to be written
//               advance           - current beat accepted by the interconnect
//               beat_data/strb    - word and strobes of the current beat
//               beat_last         - current beat is the final one of the line
// Revision    : 1.0 - initial release
// ============================================================================
module write_beat_serializer
    import write_channel_axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int BEATS  = 8
) (
    input  logic                     ap_clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [DATA_W*BEATS-1:0]  line_data,
    input  logic [DATA_W/8*BEATS-1:0] line_strb,
    input  logic                     advance,
    output logic [DATA_W-1:0]        beat_data,
    output logic [DATA_W/8-1:0]      beat_strb,
    output logic                     beat_last
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = clog2_min1(BEATS);
    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(BEATS - 1);

    logic [DATA_W*BEATS-1:0]  r_line_data;
    logic [STRB_W*BEATS-1:0]  r_line_strb;
    logic [CNT_W-1:0]         r_beat_cnt;

    // The line buffer is pure datapath; it is only observed after a load.
    always_ff @(posedge ap_clk) begin
        if (load) begin
            r_line_data <= line_data;
            r_line_strb <= line_strb;
        end
    end

    // Clearing on the last beat leaves the counter at 0 so a retried burst
    // replays the line from word 0 without reloading.
    always_ff @(posedge ap_clk) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (load) begin
            r_beat_cnt <= '0;
        end else if (advance) begin
            r_beat_cnt <= beat_last ? '0 : r_beat_cnt + CNT_W'(1);
        end
    end

    assign beat_last = (r_beat_cnt == C_LAST_IDX);

    always_comb begin
        beat_data = r_line_data[DATA_W-1:0];
        beat_strb = r_line_strb[STRB_W-1:0];
        for (int k = 0; k < BEATS; k++) begin
            if (r_beat_cnt == CNT_W'(k)) begin
                beat_data = r_line_data[k*DATA_W +: DATA_W];
                beat_strb = r_line_strb[k*STRB_W +: STRB_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/write_channel_axi_burst.sv
`default_nettype none
// ============================================================================
// Module      : write_channel_axi_burst
// Description : Accepts a full-line write request from the frontend and issues
//               it as a single AXI4 INCR burst (AW, BEATS x W, B). Completion
//               is signalled by a one-cycle done pulse, qualified by err.
//               Build option WRITE_CHANNEL_AXI_BURST_RETRY_EN: replay the
//               whole burst on an error response, up to MAX_RETRY times.
// Ports       : ap_clk, reset        - clock, synchronous active-high reset
//               valid/addr/wdata/wstrb - line-write request (line address)
//               ready                - channel idle, request will be taken
//               done, err            - completion pulse and error qualifier
//               m_axi_aw* / m_axi_w* / m_axi_b* - AXI4 write master channels
// Revision    : 1.0 - initial release
// ============================================================================
module write_channel_axi_burst
    import write_channel_axi_pkg::*;
#(
    parameter int             ADDR_W     = 32,
    parameter int             DATA_W     = 32,
    parameter int             BEATS      = 8,
    parameter int             ID_W       = 1,
    parameter logic [ID_W-1:0] AXI_ID    = '0,
    parameter logic [3:0]     CACHE_MODE = 4'b0011,
    parameter int             MAX_RETRY  = 3
) (
    input  logic                                   ap_clk,
    input  logic                                   reset,
    input  logic                                   valid,
    input  logic [ADDR_W-$clog2(DATA_W/8*BEATS)-1:0] addr,
    input  logic [DATA_W*BEATS-1:0]                wdata,
    input  logic [DATA_W/8*BEATS-1:0]              wstrb,
    output logic                                   ready,
    output logic                                   done,
    output logic                                   err,
    output logic                                   m_axi_awvalid,
    input  logic                                   m_axi_awready,
    output logic [ADDR_W-1:0]                      m_axi_awaddr,
    output logic [AWLEN_W-1:0]                     m_axi_awlen,
    output logic [AWSIZE_W-1:0]                    m_axi_awsize,
    output logic [1:0]                             m_axi_awburst,
    output logic [ID_W-1:0]                        m_axi_awid,
    output logic                                   m_axi_awlock,
    output logic [3:0]                             m_axi_awcache,
    output logic [2:0]                             m_axi_awprot,
    output logic [3:0]                             m_axi_awqos,
    output logic                                   m_axi_wvalid,
    input  logic                                   m_axi_wready,
    output logic [DATA_W-1:0]                      m_axi_wdata,
    output logic [DATA_W/8-1:0]                    m_axi_wstrb,
    output logic                                   m_axi_wlast,
    input  logic                                   m_axi_bvalid,
    input  logic [1:0]                             m_axi_bresp,
    output logic                                   m_axi_bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W * BEATS);
    localparam int LA_W   = ADDR_W - OFF_W;

    wr_state_t        r_state;
    logic [LA_W-1:0]  r_addr;
    logic             r_awvalid;
    logic             r_wvalid;
    logic             r_bready;
    logic             r_done;
    logic             r_err;

    logic             w_load;
    logic             w_beat_accept;
    logic             w_beat_last;

`ifdef WRITE_CHANNEL_AXI_BURST_RETRY_EN
    localparam int RETRY_W = clog2_min1(MAX_RETRY + 1);
    logic [RETRY_W-1:0] r_retry_cnt;
`endif

    assign w_load        = (r_state == ST_IDLE) && valid;
    // wvalid is only ever high in DATA, so a stray wready elsewhere is inert.
    assign w_beat_accept = r_wvalid && m_axi_wready;

    always_ff @(posedge ap_clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef WRITE_CHANNEL_AXI_BURST_RETRY_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_addr    <= addr;
                        r_awvalid <= 1'b1;
                        r_state   <= ST_ADDR;
`ifdef WRITE_CHANNEL_AXI_BURST_RETRY_EN
                        r_retry_cnt <= '0;
`endif
                    end
                end
                ST_ADDR: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m_axi_wready && w_beat_last) begin
                        r_wvalid <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_axi_bresp == AXI_RESP_OKAY) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
`ifdef WRITE_CHANNEL_AXI_BURST_RETRY_EN
                        else if (r_retry_cnt < RETRY_W'(MAX_RETRY)) begin
                            // Replay the whole burst from the captured line.
                            r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                            r_awvalid   <= 1'b1;
                            r_state     <= ST_ADDR;
                        end
`endif
                        else begin
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    write_beat_serializer #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_serializer (
        .ap_clk    (ap_clk),
        .reset     (reset),
        .load      (w_load),
        .line_data (wdata),
        .line_strb (wstrb),
        .advance   (w_beat_accept),
        .beat_data (m_axi_wdata),
        .beat_strb (m_axi_wstrb),
        .beat_last (w_beat_last)
    );

    assign ready         = (r_state == ST_IDLE);
    assign done          = r_done;
    assign err           = r_err;

    assign m_axi_awvalid = r_awvalid;
    assign m_axi_awaddr  = ADDR_W'(r_addr) << OFF_W;
    assign m_axi_awlen   = AWLEN_W'(BEATS - 1);
    assign m_axi_awsize  = AWSIZE_W'($clog2(STRB_W));
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = CACHE_MODE;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;

    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_wlast   = r_wvalid && w_beat_last;
    assign m_axi_bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_write_channel_axi_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_channel_axi_burst
// Description : Self-checking bench for write_channel_axi_burst (BEATS=8,
//               DATA_W=32). Expected AW addresses, beats and completion
//               flags are queued when a request is driven and compared as
//               the DUT produces them. Honours WRITE_CHANNEL_AXI_BURST_RETRY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_channel_axi_burst;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int BEATS     = 8;
    localparam int ID_W      = 1;
    localparam int MAX_RETRY = 3;
    localparam int STRB_W    = DATA_W / 8;
    localparam int LINE_W    = DATA_W * BEATS;
    localparam int LSTRB_W   = STRB_W * BEATS;
    localparam int OFF_W     = 5;
    localparam int LA_W      = ADDR_W - OFF_W;

    logic                ap_clk = 1'b0;
    logic                reset;
    logic                valid;
    logic [LA_W-1:0]     addr;
    logic [LINE_W-1:0]   wdata;
    logic [LSTRB_W-1:0]  wstrb;
    logic                ready, done, err;
    logic                m_axi_awvalid, m_axi_awready;
    logic [ADDR_W-1:0]   m_axi_awaddr;
    logic [7:0]          m_axi_awlen;
    logic [2:0]          m_axi_awsize;
    logic [1:0]          m_axi_awburst;
    logic [ID_W-1:0]     m_axi_awid;
    logic                m_axi_awlock;
    logic [3:0]          m_axi_awcache;
    logic [2:0]          m_axi_awprot;
    logic [3:0]          m_axi_awqos;
    logic                m_axi_wvalid, m_axi_wready;
    logic [DATA_W-1:0]   m_axi_wdata;
    logic [STRB_W-1:0]   m_axi_wstrb;
    logic                m_axi_wlast;
    logic                m_axi_bvalid;
    logic [1:0]          m_axi_bresp;
    logic                m_axi_bready;

    write_channel_axi_burst #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BEATS      (BEATS),
        .ID_W       (ID_W),
        .AXI_ID     (1'b0),
        .CACHE_MODE (4'b0011),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .ap_clk        (ap_clk),
        .reset         (reset),
        .valid         (valid),
        .addr          (addr),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .ready         (ready),
        .done          (done),
        .err           (err),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awlock  (m_axi_awlock),
        .m_axi_awcache (m_axi_awcache),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awqos   (m_axi_awqos),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bready  (m_axi_bready)
    );

    initial forever #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Scoreboard queues
    logic [ADDR_W-1:0] q_aw[$];
    logic [DATA_W-1:0] q_wdata[$];
    logic [STRB_W-1:0] q_wstrb[$];
    bit                q_wlast[$];
    bit                q_err[$];

    // Shared bench state
    int done_count      = 0;
    int w_hs_count      = 0;
    int b_seen          = 0;
    int fails_to_inject = 0;
    int cyc             = 0;
    int w_idx           = 0;
    int first_cyc       = 0;
    bit check_consec    = 1'b0;
    bit wready_toggle   = 1'b0;
    bit stall_prev      = 1'b0;
    logic [DATA_W-1:0] prev_wdata;
    logic [STRB_W-1:0] prev_wstrb;

    function automatic int exp_bursts(input int fails);
`ifdef WRITE_CHANNEL_AXI_BURST_RETRY_EN
        return (fails > MAX_RETRY) ? MAX_RETRY + 1 : fails + 1;
`else
        return (fails >= 0) ? 1 : 1;
`endif
    endfunction

    function automatic bit exp_err(input int fails);
`ifdef WRITE_CHANNEL_AXI_BURST_RETRY_EN
        return fails > MAX_RETRY;
`else
        return fails > 0;
`endif
    endfunction

    function automatic void push_expect(input logic [LA_W-1:0] a, input logic [LINE_W-1:0] d,
                                        input logic [LSTRB_W-1:0] s, input int fails);
        for (int b = 0; b < exp_bursts(fails); b++) begin
            q_aw.push_back({a, 5'b00000});
            for (int k = 0; k < BEATS; k++) begin
                q_wdata.push_back(d[k*DATA_W +: DATA_W]);
                q_wstrb.push_back(s[k*STRB_W +: STRB_W]);
                q_wlast.push_back(k == BEATS - 1);
            end
        end
        q_err.push_back(exp_err(fails));
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int k = 0; k < BEATS; k++) r[k*DATA_W +: DATA_W] = $urandom();
        return r;
    endfunction

    // AXI slave: awready/bvalid always high, so stray bvalid outside RESP and
    // stray wready outside DATA are continuously offered to the DUT.
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(posedge ap_clk);
            #1;
            m_axi_awready = 1'b1;
            m_axi_wready  = wready_toggle ? ~m_axi_wready : 1'b1;
            m_axi_bvalid  = 1'b1;
            m_axi_bresp   = (b_seen < fails_to_inject) ? 2'b10 : 2'b00;
        end
    end

    // Monitor: handshakes sampled on the falling edge.
    initial begin
        logic [ADDR_W-1:0] ea;
        forever begin
            @(negedge ap_clk);
            cyc++;
            if (reset) begin
                stall_prev = 1'b0;
                w_idx      = 0;
            end else begin
                if (stall_prev)
                    check("w_hold", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb},
                          {1'b1, prev_wdata, prev_wstrb});
                stall_prev = m_axi_wvalid && !m_axi_wready;
                prev_wdata = m_axi_wdata;
                prev_wstrb = m_axi_wstrb;

                if (m_axi_awvalid && m_axi_awready) begin
                    if (q_aw.size() == 0) begin
                        check("aw_unexpected", 64'd1, 64'd0);
                    end else begin
                        ea = q_aw.pop_front();
                        check("awaddr", 64'(m_axi_awaddr), 64'(ea));
                        check("awlen", 64'(m_axi_awlen), 64'd7);
                        check("awsize", 64'(m_axi_awsize), 64'd2);
                        check("awburst", 64'(m_axi_awburst), 64'd1);
                        check("awcache", 64'(m_axi_awcache), 64'd3);
                        check("aw_misc", 64'({m_axi_awid, m_axi_awlock, m_axi_awprot, m_axi_awqos}), 64'd0);
                    end
                end

                if (m_axi_wvalid && m_axi_wready) begin
                    w_hs_count++;
                    if (w_idx == 0) first_cyc = cyc;
                    if (q_wdata.size() == 0) begin
                        check("w_unexpected", 64'd1, 64'd0);
                    end else begin
                        check("wdata", 64'(m_axi_wdata), 64'(q_wdata.pop_front()));
                        check("wstrb", 64'(m_axi_wstrb), 64'(q_wstrb.pop_front()));
                        check("wlast", 64'(m_axi_wlast), 64'(q_wlast.pop_front()));
                    end
                    if (m_axi_wlast) begin
                        if (check_consec) check("burst_span", 64'(cyc - first_cyc), 64'(BEATS - 1));
                        w_idx = 0;
                    end else begin
                        w_idx++;
                    end
                end

                if (m_axi_bvalid && m_axi_bready) b_seen++;

                if (done) begin
                    done_count++;
                    if (q_err.size() == 0) check("done_unexpected", 64'd1, 64'd0);
                    else check("err", 64'(err), 64'(q_err.pop_front()));
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 500; i++) begin
            if (ready) return;
            @(posedge ap_clk);
            #1;
        end
        check("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000; i++) begin
            @(posedge ap_clk);
            #1;
            if (done_count >= target) return;
        end
        check("done_timeout", 64'(done_count), 64'(target));
    endtask

    task automatic send(input logic [LA_W-1:0] a, input logic [LINE_W-1:0] d,
                        input logic [LSTRB_W-1:0] s, input int fails);
        wait_ready();
        fails_to_inject = fails;
        b_seen          = 0;
        push_expect(a, d, s, fails);
        addr  = a;
        wdata = d;
        wstrb = s;
        valid = 1'b1;
        @(posedge ap_clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic run_one(input logic [LA_W-1:0] a, input logic [LSTRB_W-1:0] s,
                           input int fails, input string tag);
        int dc;
        dc = done_count;
        send(a, rand_line(), s, fails);
        wait_done(dc + 1);
        check(tag, 64'(q_wdata.size() + q_aw.size()), 64'd0);
    endtask

    initial begin
        logic [LINE_W-1:0]  line5, line_a, line_b;
        logic [LSTRB_W-1:0] strb_b;
        int dc, base;

        valid = 1'b0;
        addr  = '0;
        wdata = '0;
        wstrb = '0;
        reset = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        reset = 1'b0;
        @(posedge ap_clk);
        #1;
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_outs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, done, err}), 64'd0);

        // Basic burst, all readies high: 8 back-to-back beats.
        check_consec = 1'b1;
        run_one(27'h10, '1, 0, "t1_drained");
        check_consec = 1'b0;

        // wready alternating, random partial strobes.
        wready_toggle = 1'b1;
        run_one(27'h7ABC, LSTRB_W'($urandom()), 0, "t2_drained");
        wready_toggle = 1'b0;

        // Error responses: two, then four.
        run_one(27'h1234, '1, 2, "t3_drained");
        run_one(27'h0ABC, '1, 4, "t4_drained");

        // Reset while beat 3 is on the bus.
        dc    = done_count;
        base  = w_hs_count;
        line5 = rand_line();
        send(27'h55, line5, '1, 0);
        for (int i = 0; i < 200 && w_hs_count < base + 3; i++) begin
            @(posedge ap_clk);
            #1;
        end
        check("beat3_word", 64'(m_axi_wdata), 64'(line5[3*DATA_W +: DATA_W]));
        reset = 1'b1;
        @(posedge ap_clk);
        #1;
        check("midreset_outs", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, done}), 64'd0);
        check("midreset_ready", 64'(ready), 64'd1);
        reset = 1'b0;
        q_aw.delete();
        q_wdata.delete();
        q_wstrb.delete();
        q_wlast.delete();
        q_err.delete();
        repeat (5) @(posedge ap_clk);
        #1;
        check("no_done_after_reset", 64'(done_count), 64'(dc));
        run_one(27'h66, '1, 0, "t6_drained");

        // valid held high; new data presented mid-burst must wait for IDLE.
        dc     = done_count;
        line_a = rand_line();
        line_b = rand_line();
        strb_b = LSTRB_W'($urandom());
        wait_ready();
        fails_to_inject = 0;
        b_seen          = 0;
        push_expect(27'h300, line_a, '1, 0);
        push_expect(27'h301, line_b, strb_b, 0);
        addr  = 27'h300;
        wdata = line_a;
        wstrb = '1;
        valid = 1'b1;
        @(posedge ap_clk);
        #1;
        addr  = 27'h301;
        wdata = line_b;
        wstrb = strb_b;
        @(posedge ap_clk);
        #1;
        check("t7_busy", 64'(ready), 64'd0);
        wait_done(dc + 1);
        valid = 1'b0;
        check("t7_second_taken", 64'(ready), 64'd0);
        wait_done(dc + 2);
        check("t7_drained", 64'(q_wdata.size() + q_aw.size() + q_err.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/write_channel_axi_burst.md
WRITE_CHANNEL_AXI_BURST -- requirements
Module: write_channel_axi_burst

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width.
REQ-002 Parameter DATA_W, default 32, AXI beat width; power of two, at least 8.
REQ-003 Parameter BEATS, default 8, words per line; power of two, 1..256.
REQ-004 Parameter ID_W, default 1, AXI ID width.
REQ-005 Parameter AXI_ID, default 0, constant awid.
REQ-006 Parameter CACHE_MODE, default 4'b0011, constant awcache.
REQ-007 Parameter MAX_RETRY, default 3, error retries per request.
REQ-008 ap_clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-009 valid  in  1  frontend line-write request.
REQ-010 addr  in  ADDR_W-log2(DATA_W/8*BEATS)  line address.
REQ-011 wdata  in  DATA_W*BEATS  line data; word 0 in the LSBs.
REQ-012 wstrb  in  DATA_W/8*BEATS  per-byte line strobes.
REQ-013 ready  out  1  request accepted or idle.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 err  out  1  qualifies done: final response was an error.
REQ-016 m_axi_aw*  AXI4 write-address channel: awvalid/awaddr/awlen(8)/awsize(3)/awburst(2)/awid/awlock/awcache/awprot/awqos outputs, awready input.
REQ-017 m_axi_w*  wvalid/wdata(DATA_W)/wstrb(DATA_W/8)/wlast outputs, wready input.
REQ-018 m_axi_b*  bready output; bvalid and bresp(2) inputs.

Function
REQ-019 FSM states: IDLE, ADDR, DATA, RESP.
REQ-020 IDLE: ready=1; valid captures addr, wdata and wstrb into registers; next state ADDR.
REQ-021 ADDR: awvalid=1; awaddr={addr,zeros}, stable until awready; awready -> DATA.
REQ-022 Constants: awlen=BEATS-1; awsize=log2(DATA_W/8); awburst=INCR (2'b01); awlock=0; awprot=0; awqos=0; awcache=CACHE_MODE; awid=AXI_ID.
REQ-023 DATA: wvalid held high continuously; beat k drives word k and its strobe slice; counter advances on wready only.
REQ-024 wlast=1 exactly on beat BEATS-1; the wready on that beat -> RESP; counter cleared.
REQ-025 wdata/wstrb hold stable while wvalid=1 and wready=0.
REQ-026 RESP: bready=1; bvalid with bresp=2'b00 -> IDLE, done=1, err=0 in the same cycle.
REQ-027 bvalid or a stray wready seen outside RESP is ignored and has no effect.
REQ-028 valid outside IDLE is ignored; ready=0 in ADDR, DATA and RESP.
REQ-029 BEATS=1: awlen=0, wlast=1 on the only beat.

Reset
REQ-030 Reset forces IDLE; valids, bready, done, err, the beat counter and the retry counter all 0; ready=1 the cycle after reset deasserts.
REQ-031 Reset mid-burst abandons the transaction with no done pulse.

Configuration
REQ-032 Macro WRITE_CHANNEL_AXI_BURST_RETRY_EN.
REQ-033 Defined: bresp!=0 with retry count below MAX_RETRY -> count increments, state ADDR, full burst replayed from captured registers.
REQ-034 Defined: bresp!=0 with count equal to MAX_RETRY -> IDLE, done=1, err=1.
REQ-035 Undefined: any bresp!=0 -> IDLE, done=1, err=1; no retry logic synthesised.

Structure
REQ-036 Package write_channel_axi_pkg holds: the state enum, AXI_BURST_INCR, AXI_RESP_OKAY, and the awlen/awsize widths.
REQ-037 Sub-module write_beat_serializer holds the line buffer, beat counter, word/strobe mux and wlast.

Verification
REQ-038 BEATS=8, DATA_W=32, all readies 1, addr=0x10: awaddr=0x200, awlen=7, 8 consecutive beats, wlast on beat 7, done=1 err=0.
REQ-039 wready toggled 1/0 each cycle: each beat held until wready, order word0..word7, no beat lost or duplicated.
REQ-040 RETRY_EN, MAX_RETRY=3, bresp=2'b10 twice then OKAY: 3 complete bursts, identical data each time, done=1 err=0.
REQ-041 RETRY_EN, bresp=2'b10 four times: 4 bursts, then done=1 err=1; without the macro, 1 burst then err=1.
REQ-042 Reset asserted during beat 3: next cycle all valids 0, no done pulse, ready=1; the next request completes normally.
REQ-043 valid held high through a transaction, new data presented mid-burst: ignored; captured line unchanged; second request accepted only in IDLE.
